// File: rtl/mac_switch_pkg.sv
// Shared types and constants for the MAC lookup path.
package mac_switch_pkg;

  localparam int unsigned MAC_W  = 48;
  localparam int unsigned PORT_W = 3;

  localparam logic [PORT_W-1:0] PORT_FLOOD   = 3'b100;
  localparam logic [PORT_W-1:0] PORT_INVALID = 3'b110;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [MAC_W-1:0] src_mac;
    logic [MAC_W-1:0] dst_mac;
  } lookup_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;

  logic          found;
  logic [SW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = SW'((32'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/mac_lookup_arbiter.sv
// Buffers per-port header lookups and serialises them round-robin into the
// MAC engine, returning the engine result (or INVALID on watchdog) to the port.
module mac_lookup_arbiter
  import mac_switch_pkg::*;
#(
  parameter int unsigned NPORTS       = 4,
  parameter int unsigned WAIT_TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NPORTS-1:0]       req_valid,
  output logic [NPORTS-1:0]       req_ready,
  input  logic [NPORTS*MAC_W-1:0] req_src_mac,
  input  logic [NPORTS*MAC_W-1:0] req_dst_mac,
  output logic [NPORTS-1:0]       resp_valid,
  output logic [PORT_W-1:0]       resp_dst_port,
  output logic                    ml_en,
  output logic [MAC_W-1:0]        ml_src_mac,
  output logic [MAC_W-1:0]        ml_dst_mac,
  output logic [PORT_W-1:0]       ml_src_port,
  input  logic                    ml_busy,
  input  logic                    ml_done,
  input  logic [PORT_W-1:0]       ml_dst_port,
  output logic                    timeout
);

  localparam int unsigned WD_W = $clog2(WAIT_TIMEOUT + 1);

  arb_state_t               state_q, state_d;
  logic [NPORTS-1:0]        pending_q, pending_d;
  lookup_req_t [NPORTS-1:0] buf_q;
  logic [PORT_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PORT_W-1:0]        grant_q, grant_d;
  logic [NPORTS-1:0]        grant_oh_q, grant_oh_d;
  logic [WD_W-1:0]          wd_q, wd_d;
  logic                     ml_en_q, ml_en_d;
  logic [MAC_W-1:0]         ml_src_mac_q, ml_src_mac_d;
  logic [MAC_W-1:0]         ml_dst_mac_q, ml_dst_mac_d;
  logic [PORT_W-1:0]        ml_src_port_q, ml_src_port_d;
  logic [NPORTS-1:0]        resp_valid_q, resp_valid_d;
  logic [PORT_W-1:0]        resp_dst_port_q, resp_dst_port_d;
  logic                     timeout_q, timeout_d;

  logic [NPORTS-1:0]        accept;
  logic [NPORTS-1:0]        pend_clr;
  logic [NPORTS-1:0]        arb_gnt;
  logic [PORT_W-1:0]        arb_idx;
  lookup_req_t              arb_sel;

  assign accept = req_valid & ~pending_q;

  rr_arbiter #(
    .N  (NPORTS),
    .IW (PORT_W)
  ) u_rr_arbiter (
    .req     (pending_q),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // One-hot mux of the buffer selected by the arbiter.
  always_comb begin
    arb_sel = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      if (arb_gnt[i]) arb_sel = buf_q[i];
    end
  end

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    grant_oh_d      = grant_oh_q;
    rr_ptr_d        = rr_ptr_q;
    wd_d            = wd_q;
    ml_en_d         = 1'b0;
    ml_src_mac_d    = ml_src_mac_q;
    ml_dst_mac_d    = ml_dst_mac_q;
    ml_src_port_d   = ml_src_port_q;
    resp_valid_d    = '0;
    resp_dst_port_d = resp_dst_port_q;
    timeout_d       = 1'b0;
    pend_clr        = '0;

    case (state_q)
      ARB_IDLE: begin
        if ((|pending_q) && !ml_busy) begin
          grant_d       = arb_idx;
          grant_oh_d    = arb_gnt;
          ml_src_mac_d  = arb_sel.src_mac;
          ml_dst_mac_d  = arb_sel.dst_mac;
          ml_src_port_d = arb_idx;
          ml_en_d       = 1'b1;
          state_d       = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        wd_d    = '0;
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        // A done arriving on the expiry cycle still wins over the watchdog.
        if (ml_done) begin
          resp_dst_port_d = ml_dst_port;
          resp_valid_d    = grant_oh_q;
          state_d         = ARB_RESP;
        end else if (wd_q == WD_W'(WAIT_TIMEOUT - 1)) begin
          resp_dst_port_d = PORT_INVALID;
          resp_valid_d    = grant_oh_q;
          timeout_d       = 1'b1;
          state_d         = ARB_RESP;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ARB_RESP: begin
        pend_clr = grant_oh_q;
        rr_ptr_d = (grant_q == PORT_W'(NPORTS - 1)) ? '0 : grant_q + PORT_W'(1);
        state_d  = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase

    pending_d = (pending_q | accept) & ~pend_clr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ARB_IDLE;
      pending_q       <= '0;
      buf_q           <= '0;
      rr_ptr_q        <= '0;
      grant_q         <= '0;
      grant_oh_q      <= '0;
      wd_q            <= '0;
      ml_en_q         <= 1'b0;
      ml_src_mac_q    <= '0;
      ml_dst_mac_q    <= '0;
      ml_src_port_q   <= '0;
      resp_valid_q    <= '0;
      resp_dst_port_q <= PORT_INVALID;
      timeout_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      pending_q       <= pending_d;
      rr_ptr_q        <= rr_ptr_d;
      grant_q         <= grant_d;
      grant_oh_q      <= grant_oh_d;
      wd_q            <= wd_d;
      ml_en_q         <= ml_en_d;
      ml_src_mac_q    <= ml_src_mac_d;
      ml_dst_mac_q    <= ml_dst_mac_d;
      ml_src_port_q   <= ml_src_port_d;
      resp_valid_q    <= resp_valid_d;
      resp_dst_port_q <= resp_dst_port_d;
      timeout_q       <= timeout_d;
      for (int unsigned i = 0; i < NPORTS; i++) begin
        if (accept[i]) begin
          buf_q[i].src_mac <= req_src_mac[i*MAC_W +: MAC_W];
          buf_q[i].dst_mac <= req_dst_mac[i*MAC_W +: MAC_W];
        end
      end
    end
  end

  assign req_ready     = ~pending_q;
  assign resp_valid    = resp_valid_q;
  assign resp_dst_port = resp_dst_port_q;
  assign ml_en         = ml_en_q;
  assign ml_src_mac    = ml_src_mac_q;
  assign ml_dst_mac    = ml_dst_mac_q;
  assign ml_src_port   = ml_src_port_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_mac_lookup_arbiter.sv
// Directed bench for mac_lookup_arbiter with a hand-driven engine stub.
module tb_mac_lookup_arbiter;
  import mac_switch_pkg::*;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [47:0]  src_a [4];
  logic [47:0]  dst_a [4];
  logic [191:0] req_src_mac;
  logic [191:0] req_dst_mac;
  logic [3:0]   resp_valid;
  logic [2:0]   resp_dst_port;
  logic         ml_en;
  logic [47:0]  ml_src_mac;
  logic [47:0]  ml_dst_mac;
  logic [2:0]   ml_src_port;
  logic         ml_busy;
  logic         ml_done;
  logic [2:0]   ml_dst_port;
  logic         timeout;

  int checks;
  int errors;

  assign req_src_mac = {src_a[3], src_a[2], src_a[1], src_a[0]};
  assign req_dst_mac = {dst_a[3], dst_a[2], dst_a[1], dst_a[0]};

  mac_lookup_arbiter #(.NPORTS(4), .WAIT_TIMEOUT(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_src_mac   (req_src_mac),
    .req_dst_mac   (req_dst_mac),
    .resp_valid    (resp_valid),
    .resp_dst_port (resp_dst_port),
    .ml_en         (ml_en),
    .ml_src_mac    (ml_src_mac),
    .ml_dst_mac    (ml_dst_mac),
    .ml_src_port   (ml_src_port),
    .ml_busy       (ml_busy),
    .ml_done       (ml_done),
    .ml_dst_port   (ml_dst_port),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req(input logic [1:0] p, input logic [47:0] s, input logic [47:0] d);
    src_a[p] = s;
    dst_a[p] = d;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic wait_en(input string tag);
    int n;
    n = 0;
    while (ml_en !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, " en_seen"}, 64'(ml_en), 64'd1);
  endtask

  // From ISSUE through the RESP cycle; engine answers after three WAIT cycles.
  task automatic serve_to_resp(input string tag, input logic [1:0] p, input logic [2:0] res,
                               input logic [47:0] s, input logic [47:0] d);
    logic [3:0] m;
    m = 4'b0001 << p;
    wait_en(tag);
    chk({tag, " src_port"}, 64'(ml_src_port), 64'(p));
    chk({tag, " src_mac"}, 64'(ml_src_mac), 64'(s));
    chk({tag, " dst_mac"}, 64'(ml_dst_mac), 64'(d));
    tick();
    chk({tag, " en_pulse"}, 64'(ml_en), 64'd0);
    tick();
    tick();
    ml_done     = 1'b1;
    ml_dst_port = res;
    tick();
    ml_done     = 1'b0;
    ml_dst_port = 3'b000;
    chk({tag, " resp_valid"}, 64'(resp_valid), 64'(m));
    chk({tag, " resp_port"}, 64'(resp_dst_port), 64'(res));
    chk({tag, " no_timeout"}, 64'(timeout), 64'd0);
    chk({tag, " busy_in_resp"}, 64'(req_ready[p]), 64'd0);
  endtask

  task automatic serve_tail(input string tag, input logic [1:0] p);
    tick();
    chk({tag, " resp_pulse"}, 64'(resp_valid), 64'd0);
    chk({tag, " freed"}, 64'(req_ready[p]), 64'd1);
  endtask

  task automatic serve(input string tag, input logic [1:0] p, input logic [2:0] res,
                       input logic [47:0] s, input logic [47:0] d);
    serve_to_resp(tag, p, res, s, d);
    serve_tail(tag, p);
  endtask

  initial begin
    int n;
    int cnt;
    checks      = 0;
    errors      = 0;
    clk         = 1'b0;
    rst         = 1'b0;
    req_valid   = '0;
    ml_busy     = 1'b0;
    ml_done     = 1'b0;
    ml_dst_port = 3'b000;
    for (int i = 0; i < 4; i++) begin
      src_a[i] = '0;
      dst_a[i] = '0;
    end
    tick();
    tick();
    chk("rst req_ready", 64'(req_ready), 64'hF);
    chk("rst resp_port", 64'(resp_dst_port), 64'h6);
    chk("rst resp_valid", 64'(resp_valid), 64'h0);
    chk("rst ml_en", 64'(ml_en), 64'h0);
    chk("rst timeout", 64'(timeout), 64'h0);
    chk("rst src_port", 64'(ml_src_port), 64'h0);
    rst = 1'b1;
    tick();

    // 1: single request on port 2
    set_req(2'd2, 48'h02_00_00_00_00_01, 48'hAA_AA_AA_AA_AA_AA);
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0000;
    chk("t1 accepted", 64'(req_ready), 64'hB);
    chk("t1 not_yet", 64'(ml_en), 64'h0);
    serve("t1", 2'd2, 3'b001, 48'h02_00_00_00_00_01, 48'hAA_AA_AA_AA_AA_AA);

    // 2: all four at once from a fresh pointer
    do_reset();
    set_req(2'd0, 48'h10_00_00_00_00_00, 48'h20_00_00_00_00_00);
    set_req(2'd1, 48'h10_00_00_00_00_01, 48'h20_00_00_00_00_01);
    set_req(2'd2, 48'h10_00_00_00_00_02, 48'h20_00_00_00_00_02);
    set_req(2'd3, 48'h10_00_00_00_00_03, 48'h20_00_00_00_00_03);
    req_valid = 4'b1111;
    tick();
    req_valid = 4'b0000;
    chk("t2 all_pending", 64'(req_ready), 64'h0);
    serve("t2 p0", 2'd0, 3'b101, 48'h10_00_00_00_00_00, 48'h20_00_00_00_00_00);
    serve("t2 p1", 2'd1, PORT_FLOOD, 48'h10_00_00_00_00_01, 48'h20_00_00_00_00_01);
    serve("t2 p2", 2'd2, 3'b011, 48'h10_00_00_00_00_02, 48'h20_00_00_00_00_02);
    serve("t2 p3", 2'd3, 3'b010, 48'h10_00_00_00_00_03, 48'h20_00_00_00_00_03);
    // pointer wrapped to 0: port 0 must beat port 3
    set_req(2'd0, 48'h30_00_00_00_00_00, 48'h40_00_00_00_00_00);
    set_req(2'd3, 48'h30_00_00_00_00_03, 48'h40_00_00_00_00_03);
    req_valid = 4'b1001;
    tick();
    req_valid = 4'b0000;
    serve("t2 r2p0", 2'd0, 3'b000, 48'h30_00_00_00_00_00, 48'h40_00_00_00_00_00);
    serve("t2 r2p3", 2'd3, 3'b111, 48'h30_00_00_00_00_03, 48'h40_00_00_00_00_03);

    // 3: engine busy holds off the start
    ml_busy = 1'b1;
    set_req(2'd1, 48'h51_51_51_51_51_51, 48'h61_61_61_61_61_61);
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0000;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ml_en === 1'b1) cnt++;
    end
    chk("t3 no_en_busy", 64'(cnt), 64'd0);
    ml_busy = 1'b0;
    tick();
    chk("t3 en_after_busy", 64'(ml_en), 64'd1);
    serve("t3", 2'd1, 3'b010, 48'h51_51_51_51_51_51, 48'h61_61_61_61_61_61);

    // 4: lost done, watchdog fires after 64 WAIT cycles
    set_req(2'd3, 48'h73_00_00_00_00_73, 48'h83_00_00_00_00_83);
    req_valid = 4'b1000;
    tick();
    req_valid = 4'b0000;
    wait_en("t4");
    n = 0;
    while (timeout !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("t4 timeout_delay", 64'(n), 64'd65);
    chk("t4 resp_valid", 64'(resp_valid), 64'h8);
    chk("t4 resp_port", 64'(resp_dst_port), 64'h6);
    tick();
    chk("t4 timeout_pulse", 64'(timeout), 64'd0);
    chk("t4 cleared", 64'(req_ready), 64'hF);

    // 4b: done on the expiry cycle wins
    set_req(2'd0, 48'h70_00_00_00_00_70, 48'h80_00_00_00_00_80);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    wait_en("t4b");
    for (int i = 0; i < 64; i++) tick();
    ml_done     = 1'b1;
    ml_dst_port = 3'b001;
    tick();
    ml_done     = 1'b0;
    ml_dst_port = 3'b000;
    chk("t4b no_timeout", 64'(timeout), 64'd0);
    chk("t4b resp_port", 64'(resp_dst_port), 64'h1);
    chk("t4b resp_valid", 64'(resp_valid), 64'h1);
    tick();

    // 5: reset while waiting on the engine
    set_req(2'd0, 48'h90_00_00_00_00_00, 48'hA0_00_00_00_00_00);
    set_req(2'd3, 48'h90_00_00_00_00_03, 48'hA0_00_00_00_00_03);
    req_valid = 4'b1001;
    tick();
    req_valid = 4'b0000;
    wait_en("t5");
    tick();
    #2 rst = 1'b0;
    #1;
    chk("t5 async req_ready", 64'(req_ready), 64'hF);
    chk("t5 async src_mac", 64'(ml_src_mac), 64'h0);
    chk("t5 async src_port", 64'(ml_src_port), 64'h0);
    chk("t5 async resp_port", 64'(resp_dst_port), 64'h6);
    tick();
    rst     = 1'b1;
    ml_done = 1'b1;
    tick();
    ml_done = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid !== 4'b0000 || ml_en !== 1'b0) cnt++;
      tick();
    end
    chk("t5 silent_after_rst", 64'(cnt), 64'd0);

    // 6: port 0 re-requests during its RESP cycle
    set_req(2'd0, 48'hC0_C0_C0_C0_C0_C0, 48'hD0_D0_D0_D0_D0_D0);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    serve_to_resp("t6a", 2'd0, 3'b011, 48'hC0_C0_C0_C0_C0_C0, 48'hD0_D0_D0_D0_D0_D0);
    set_req(2'd0, 48'hE0_E0_E0_E0_E0_E0, 48'hF0_F0_F0_F0_F0_F0);
    req_valid = 4'b0001;
    serve_tail("t6a", 2'd0);
    tick();
    req_valid = 4'b0000;
    chk("t6 accepted_next", 64'(req_ready), 64'hE);
    serve("t6b", 2'd0, 3'b101, 48'hE0_E0_E0_E0_E0_E0, 48'hF0_F0_F0_F0_F0_F0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
